// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 access codes,
// byte-strobe size masks and the bus-transaction FSM state type.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Valid/ready data-memory bus between the LSU (master) and the memory (slave).
interface lsu_mem_stage_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic [DATA_W-1:0]     mem_req_wdata;
  logic [DATA_W/8-1:0]   mem_req_wstrb;
  logic                  mem_rsp_valid;
  logic [DATA_W-1:0]     mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for an 8-lane bus: misalignment detect, store strobes and
// shifted write data, and load extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [2:0]  funct3,
  input  logic [63:0] store_data,
  input  logic [63:0] load_raw,
  output logic        misalign,
  output logic [7:0]  strb,
  output logic [63:0] wdata,
  output logic [63:0] load_data
);

  logic [7:0]  size_mask;
  logic [63:0] shifted;

  always_comb begin
    size_mask = STRB_D;
    misalign  = 1'b0;
    unique case (funct3[1:0])
      2'b00: begin
        size_mask = STRB_B;
        misalign  = 1'b0;
      end
      2'b01: begin
        size_mask = STRB_H;
        misalign  = off[0];
      end
      2'b10: begin
        size_mask = STRB_W;
        misalign  = |off[1:0];
      end
      default: begin
        size_mask = STRB_D;
        misalign  = |off;
      end
    endcase
  end

  assign strb    = size_mask << off;
  assign wdata   = store_data << {off, 3'b000};
  assign shifted = load_raw >> {off, 3'b000};

  // funct3 111 has no load of its own and falls through to the full doubleword.
  always_comb begin
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{56{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
      F3_BU:   load_data = {56'd0, shifted[7:0]};
      F3_HU:   load_data = {48'd0, shifted[15:0]};
      F3_WU:   load_data = {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one valid/ready bus transaction per memory instruction.
// Optional response watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [2:0]        funct3M,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              MisalignM,
  output logic              BusErrM,
  lsu_mem_stage_if.master   bus
);

  if (DATA_W != 64) begin : g_bad_data_w
    $error("lsu_mem_stage: DATA_W must be 64");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("lsu_mem_stage: TIMEOUT_CYCLES must be at least 1");
  end

  lsu_state_t        state_q, state_d;
  logic              acc, issue, reject;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [63:0]       req_wdata_q;
  logic [7:0]        req_wstrb_q;
  logic [2:0]        off_q, f3_q;
  logic              misalign_q;
  logic              timeout;

  logic [2:0]  sel_off, sel_f3;
  logic        misalign;
  logic [7:0]  lane_strb;
  logic [63:0] lane_wdata, load_data;

  assign acc    = MemReadM | MemWriteM;
  assign issue  = (state_q == StIdle) && acc && !misalign;
  assign reject = (state_q == StIdle) && acc && misalign;

  // Live instruction fields drive the aligner in IDLE; the registered copy afterwards.
  assign sel_off = (state_q == StIdle) ? ALUResultM[2:0] : off_q;
  assign sel_f3  = (state_q == StIdle) ? funct3M : f3_q;

  lsu_lane_align u_lane_align (
    .off        (sel_off),
    .funct3     (sel_f3),
    .store_data (WriteDataM),
    .load_raw   (bus.mem_rsp_rdata),
    .misalign   (misalign),
    .strb       (lane_strb),
    .wdata      (lane_wdata),
    .load_data  (load_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            bus_err_q;

  assign timeout = (state_q == StResp) && !bus.mem_rsp_valid &&
                   (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout;
      if ((state_q == StReq) && bus.mem_req_ready) begin
        cnt_q <= '0;
      end else if (state_q == StResp) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign BusErrM = bus_err_q;
`else
  assign timeout = 1'b0;
  assign BusErrM = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    StallM  = 1'b0;
    unique case (state_q)
      StIdle: begin
        StallM = acc;
        if (acc) state_d = misalign ? StDone : StReq;
      end
      StReq: begin
        StallM = 1'b1;
        if (bus.mem_req_ready) state_d = StResp;
      end
      StResp: begin
        StallM = 1'b1;
        if (bus.mem_rsp_valid || timeout) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      misalign_q  <= 1'b0;
      ReadDataM   <= '0;
    end else begin
      state_q    <= state_d;
      misalign_q <= reject;
      if (issue) begin
        req_we_q    <= MemWriteM;
        req_addr_q  <= {ALUResultM[ADDR_W-1:3], 3'b000};
        req_wdata_q <= MemWriteM ? lane_wdata : 64'd0;
        req_wstrb_q <= MemWriteM ? lane_strb : 8'd0;
        off_q       <= ALUResultM[2:0];
        f3_q        <= funct3M;
      end
      if (reject || timeout) begin
        ReadDataM <= '0;
      end else if ((state_q == StResp) && bus.mem_rsp_valid && !req_we_q) begin
        ReadDataM <= load_data;
      end
    end
  end

  assign bus.mem_req_valid = (state_q == StReq);
  assign bus.mem_req_we    = req_we_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wdata = req_wdata_q;
  assign bus.mem_req_wstrb = req_wstrb_q;
  assign MisalignM         = misalign_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus randomized accesses
// against a byte-level reference model of lane steering and extension.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [63:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, MisalignM, BusErrM;

  int vectors     = 0;
  int miscompares = 0;
  logic [63:0] last_rd = '0;

  lsu_mem_stage_if #(.ADDR_W(64), .DATA_W(64)) bus_if ();

  lsu_mem_stage #(
    .ADDR_W         (64),
    .DATA_W         (64),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes and byte-by-byte lane arithmetic.
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [63:0] addr);
    return (int'(addr[2:0]) % acc_size(f3)) != 0;
  endfunction

  function automatic logic [7:0] model_strb(input logic [2:0] f3, input logic [63:0] addr);
    logic [7:0] s;
    int off;
    s = '0;
    off = int'(addr[2:0]);
    for (int b = 0; b < 8; b++) s[b] = (b >= off) && (b < off + acc_size(f3));
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] addr, input logic [63:0] wd);
    logic [63:0] w;
    int off;
    w = '0;
    off = int'(addr[2:0]);
    for (int b = 0; b < 8; b++) if (b >= off) w[8*b +: 8] = wd[8*(b-off) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr,
                                             input logic [63:0] rdata);
    logic [63:0] v;
    int off, size;
    v = '0;
    off = int'(addr[2:0]);
    size = acc_size(f3);
    for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!f3[2] && size < 8 && v[8*size-1])
      for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] wd,
                            input logic [63:0] rdata, input int rdy_dly, input int rsp_dly);
    bit mis, timed, in_resp, next_resp, done, saw_valid;
    int stalls, req_cnt, resp_cnt, cyc, exp_stalls;
    logic [63:0] exp_rd;
    mis   = is_misaligned(f3, addr);
    timed = TimeoutOn && !mis && (rsp_dly >= TO);
    exp_stalls = mis ? 1 : 2 + rdy_dly + (timed ? TO : rsp_dly + 1);
    exp_rd = last_rd;
    if (mis || timed) exp_rd = '0;
    else if (!wr) exp_rd = model_load(f3, addr, rdata);
    {in_resp, next_resp, done, saw_valid} = '0;
    {stalls, req_cnt, resp_cnt, cyc} = '0;

    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    #1;
    while (!done && cyc < 64) begin
      if (!StallM) begin
        done = 1'b1;
      end else begin
        stalls++;
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.mem_req_ready = 1'b0;
        bus_if.mem_rsp_rdata = {$urandom, $urandom};
        next_resp = in_resp;
        if (in_resp) begin
          if (resp_cnt == rsp_dly) begin
            bus_if.mem_rsp_valid = 1'b1;
            bus_if.mem_rsp_rdata = rdata;
          end
          resp_cnt++;
        end else if (bus_if.mem_req_valid) begin
          saw_valid = 1'b1;
          chk("req_addr", bus_if.mem_req_addr, {addr[63:3], 3'b000});
          chk("req_we", 64'(bus_if.mem_req_we), 64'(wr));
          chk("req_wstrb", 64'(bus_if.mem_req_wstrb), wr ? 64'(model_strb(f3, addr)) : 64'd0);
          if (wr) chk("req_wdata", bus_if.mem_req_wdata, model_wdata(addr, wd));
          // Stray responses outside RESP must be ignored.
          bus_if.mem_rsp_valid = 1'($urandom_range(0, 1));
          if (req_cnt == rdy_dly) begin
            bus_if.mem_req_ready = 1'b1;
            next_resp = 1'b1;
          end
          req_cnt++;
        end
        @(negedge clk);
        #1;
        cyc++;
        in_resp = next_resp;
      end
    end
    chk("done_reached", 64'(done), 64'd1);
    chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
    chk("bus_used", 64'(saw_valid), 64'(!mis));
    chk("misalign_done", 64'(MisalignM), 64'(mis));
    chk("buserr_done", 64'(BusErrM), 64'(timed));
    chk("read_data", ReadDataM, exp_rd);
    last_rd = exp_rd;

    MemReadM = 1'b0; MemWriteM = 1'b0;
    bus_if.mem_rsp_valid = 1'b0; bus_if.mem_req_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("misalign_pulse", 64'(MisalignM), 64'd0);
    chk("idle_stall", 64'(StallM), 64'd0);
    chk("idle_valid", 64'(bus_if.mem_req_valid), 64'd0);
  endtask

  int unsigned mode;
  bit r_rd, r_wr;
  logic [2:0] r_f3;
  logic [63:0] r_addr;

  initial begin
    rst = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = '0; ALUResultM = '0; WriteDataM = '0;
    bus_if.mem_req_ready = 1'b0; bus_if.mem_rsp_valid = 1'b0; bus_if.mem_rsp_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_readdata", ReadDataM, 64'd0);
    chk("rst_valid", 64'(bus_if.mem_req_valid), 64'd0);
    chk("rst_misalign", 64'(MisalignM), 64'd0);
    chk("rst_buserr", 64'(BusErrM), 64'd0);
    chk("rst_stall", 64'(StallM), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_access(1, 0, F3_D, 64'h1000, 64'd0, 64'h1122334455667788, 0, 0);
    chk("ld_const", ReadDataM, 64'h1122334455667788);
`ifdef LSU_TIMEOUT_EN
    run_access(1, 0, F3_D, 64'h5000, 64'd0, 64'hDEAD, 0, 100);
    chk("timeout_rd", ReadDataM, 64'd0);
`endif
    run_access(1, 0, F3_B, 64'h1005, 64'd0, 64'h000080FF00000000, 0, 0);
    chk("lb_const", ReadDataM, 64'hFFFFFFFFFFFFFF80);
    run_access(1, 0, F3_BU, 64'h1005, 64'd0, 64'h000080FF00000000, 1, 2);
    chk("lbu_const", ReadDataM, 64'h80);
    run_access(0, 1, F3_H, 64'h2002, 64'hABCD, 64'd0, 0, 0);
    chk("sh_holds_rd", ReadDataM, 64'h80);
    run_access(1, 0, F3_W, 64'h3002, 64'd0, 64'd0, 0, 0);

    // Backpressure for 5 cycles, then reset while waiting for the response.
    @(negedge clk);
    MemReadM = 1'b1; funct3M = F3_D; ALUResultM = 64'h4008;
    #1;
    chk("bp_idle_stall", 64'(StallM), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 64'(bus_if.mem_req_valid), 64'd1);
      chk("bp_addr", bus_if.mem_req_addr, 64'h4008);
      chk("bp_stall", 64'(StallM), 64'd1);
      bus_if.mem_req_ready = (i == 5);
    end
    @(negedge clk);
    #1;
    bus_if.mem_req_ready = 1'b0;
    chk("bp_resp_stall", 64'(StallM), 64'd1);
    rst = 1'b0;
    MemReadM = 1'b0;
    #1;
    chk("async_valid", 64'(bus_if.mem_req_valid), 64'd0);
    chk("async_idle", 64'(StallM), 64'd0);
    chk("async_rd", ReadDataM, 64'd0);
    last_rd = '0;
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 2);
      r_rd = (mode != 1);
      r_wr = (mode != 0);
      r_f3 = r_wr ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      r_addr = {$urandom, $urandom};
      run_access(r_rd, r_wr, r_f3, r_addr, {$urandom, $urandom}, {$urandom, $urandom},
                 $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
